// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per clock.
// Optional addend port C (P = A*B + C) enabled by defining MULT_ADDEND_EN.
module seq_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
`ifdef MULT_ADDEND_EN
   input  logic [WIDTH-1:0]   C,
`endif
   output logic [2*WIDTH-1:0] P,
   output logic               done,
   output logic               busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] add_term;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] acc_init;
   logic [CW-1:0]      count;
   logic               last;

   assign last     = (count == CW'(WIDTH - 1));
   assign add_term = mplier[0] ? mcand : '0;
   assign acc_next = acc + add_term;

`ifdef MULT_ADDEND_EN
   assign acc_init = {{WIDTH{1'b0}}, C};
`else
   assign acc_init = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start) state_d = CALC;
         CALC:       if (last)  state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // P is written only on the final iteration so partial sums never leak out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         P      <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, A};
                  mplier <= B;
                  acc    <= acc_init;
                  count  <= '0;
                  done   <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            CALC: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CW'(1);
               if (last) begin
                  P    <= acc_next;
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
